// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver: double-buffered digit data applied at
// frame boundaries, anti-ghosting dead time, blink, blank and leading-zero blanking.
module seg_scan_display #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEAD           = 16,
   parameter int BLINK_DIV      = 128,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic [DIGITS-1:0]     blink_in,
   input  logic                  lz_en,
   output logic                  pending,
   output logic                  frame_start,
   output logic [7:0]            seg_d,
   output logic [DIGITS-1:0]     seg_w
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]     CNT_DEAD = CW'(DEAD);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [FW-1:0]     FRM_LAST = FW'(BLINK_DIV - 1);
   localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [FW-1:0]       frm_q, frm_d;
   logic                bph_q, bph_d;
   logic                pend_q, pend_d;

   logic [4*DIGITS-1:0] stg_data_q, shd_data_q;
   logic [DIGITS-1:0]   stg_dp_q, shd_dp_q;
   logic [DIGITS-1:0]   stg_blank_q, shd_blank_q;
   logic [DIGITS-1:0]   stg_blink_q, shd_blink_q;
   logic                stg_lz_q, shd_lz_q;

   logic [7:0]          seg_q, seg_d_n;
   logic [DIGITS-1:0]   dig_q, dig_d;
   logic                fs_q, fs_d;

   logic                cnt_wrap, frame_bnd;
   logic [DIGITS-1:0]   lz_mask;

   // Scan timing, blink timebase and load/pending handshake
   always_comb begin
      cnt_wrap  = (cnt_q == CNT_LAST);
      frame_bnd = cnt_wrap && (idx_q == IDX_LAST);
      cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      frm_d = frm_q;
      bph_d = bph_q;
      if (frame_bnd) begin
         if (frm_q == FRM_LAST) begin
            frm_d = '0;
            bph_d = ~bph_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
      pend_d = pend_q;
      if (load) begin
         pend_d = 1'b1;
      end else if (frame_bnd) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         frm_q  <= '0;
         bph_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         frm_q  <= frm_d;
         bph_q  <= bph_d;
         pend_q <= pend_d;
      end
   end

   // Staging and shadow buffers; shadow copies the pre-edge staged value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_data_q  <= '0;
         stg_dp_q    <= '0;
         stg_blank_q <= '1;
         stg_blink_q <= '0;
         stg_lz_q    <= 1'b0;
         shd_data_q  <= '0;
         shd_dp_q    <= '0;
         shd_blank_q <= '1;
         shd_blink_q <= '0;
         shd_lz_q    <= 1'b0;
      end else begin
         if (load) begin
            stg_data_q  <= data_in;
            stg_dp_q    <= dp_in;
            stg_blank_q <= blank_in;
            stg_blink_q <= blink_in;
            stg_lz_q    <= lz_en;
         end
         if (frame_bnd && pend_q) begin
            shd_data_q  <= stg_data_q;
            shd_dp_q    <= stg_dp_q;
            shd_blank_q <= stg_blank_q;
            shd_blink_q <= stg_blink_q;
            shd_lz_q    <= stg_lz_q;
         end
      end
   end

   always_comb begin
      logic run;
      lz_mask = '0;
      run     = shd_lz_q;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (shd_data_q[4*k +: 4] != 4'h0) begin
            run = 1'b0;
         end
         lz_mask[k] = run;
      end
   end

   // Segment/enable generation for the digit currently being scanned
   always_comb begin
      logic [3:0] nib;
      logic       dp_c, blank_c, blink_c, lz_c, dark, en;
      logic [7:0] seg_raw;
      nib     = 4'h0;
      dp_c    = 1'b0;
      blank_c = 1'b0;
      blink_c = 1'b0;
      lz_c    = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            nib     = shd_data_q[4*k +: 4];
            dp_c    = shd_dp_q[k];
            blank_c = shd_blank_q[k];
            blink_c = shd_blink_q[k];
            lz_c    = lz_mask[k];
         end
      end
      // A fully dark digit is also left un-enabled; zero suppression keeps dp, so it stays enabled
      dark    = blank_c | (blink_c & bph_q);
      seg_raw = {dp_c, lz_c ? 7'h00 : seg_decode(nib)};
      en      = ~dark;
      if (dark || (cnt_q < CNT_DEAD)) begin
         seg_raw = 8'h00;
         en      = 1'b0;
      end
      seg_d_n = seg_raw ^ SEG_OFF;
      dig_d   = (en ? (DIGITS'(1) << idx_q) : {DIGITS{1'b0}}) ^ DIG_OFF;
      fs_d    = (idx_q == '0) && (cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_OFF;
         dig_q <= DIG_OFF;
         fs_q  <= 1'b0;
      end else begin
         seg_q <= seg_d_n;
         dig_q <= dig_d;
         fs_q  <= fs_d;
      end
   end

   assign seg_d       = seg_q;
   assign seg_w       = dig_q;
   assign frame_start = fs_q;
   assign pending     = pend_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: expected per-cycle outputs are queued
// when each load is issued and compared as the DUT scans them out.
module tb_seg_scan_display;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 8;
   localparam int DEAD      = 2;
   localparam int BLINK_DIV = 2;
   localparam int FRAME     = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in, blank_in, blink_in;
   logic        lz_en;
   logic        pending, frame_start;
   logic [7:0]  seg_d;
   logic [3:0]  seg_w;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct {
      int         t;
      logic [7:0] seg;
      logic [3:0] dig;
      logic       fs;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   seg_scan_display #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD), .BLINK_DIV(BLINK_DIV),
      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
      .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en), .pending(pending),
      .frame_start(frame_start), .seg_d(seg_d), .seg_w(seg_w)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      if (obs !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, req, cyc);
      end
   endtask

   // Patterns are active-high {dp,gfedcba}; on[k]=0 means digit k fully dark and un-enabled
   task automatic push_frame(input int f, input logic [7:0] p3, input logic [7:0] p2,
                             input logic [7:0] p1, input logic [7:0] p0, input logic [3:0] on);
      logic [7:0] pat [4];
      exp_t e;
      pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
      for (int k = 0; k < DIGITS; k++) begin
         for (int c = 0; c < SCAN_DIV; c++) begin
            e.t  = FRAME * f + SCAN_DIV * k + c + 1;
            e.fs = (k == 0) && (c == 0);
            if (c < DEAD || !on[k]) begin
               e.seg = 8'hFF;
               e.dig = 4'hF;
            end else begin
               e.seg = ~pat[k];
               e.dig = ~(4'b0001 << k);
            end
            sb.push_back(e);
         end
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                          input logic [3:0] bk, input logic lz);
      data_in  = d;
      dp_in    = dp;
      blank_in = bl;
      blink_in = bk;
      lz_en    = lz;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && sb.size() > 0) begin
         if (sb[0].t == cyc) begin
            mon_e = sb.pop_front();
            chk("seg_d", {24'h0, seg_d}, {24'h0, mon_e.seg});
            chk("seg_w", {28'h0, seg_w}, {28'h0, mon_e.dig});
            chk("frame_start", {31'h0, frame_start}, {31'h0, mon_e.fs});
         end else if (sb[0].t < cyc) begin
            chk("sb_order", cyc, sb[0].t);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
      blank_in = '0; blink_in = '0; lz_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_seg_d", {24'h0, seg_d}, 32'hFF);
      chk("rst_seg_w", {28'h0, seg_w}, 32'hF);
      chk("rst_fs", {31'h0, frame_start}, 32'h0);
      chk("rst_pending", {31'h0, pending}, 32'h0);

      // Idle: dark display for two frames
      push_frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      push_frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      rst_n = 1'b1;
      wait_cyc(20);
      chk("pend_idle", {31'h0, pending}, 32'h0);

      // 12AF with dp on digit 2, applied at the frame 1->2 boundary
      wait_cyc(40);
      push_frame(2, 8'h06, 8'hDB, 8'h77, 8'h71, 4'b1111);
      push_frame(3, 8'h06, 8'hDB, 8'h77, 8'h71, 4'b1111);
      do_load(16'h12AF, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      chk("pend_rise", {31'h0, pending}, 32'h1);
      wait_cyc(63);
      chk("pend_hold", {31'h0, pending}, 32'h1);
      wait_cyc(64);
      chk("pend_fall", {31'h0, pending}, 32'h0);

      // Two loads; the second on the boundary edge
      wait_cyc(99);
      push_frame(4, 8'h06, 8'h06, 8'h06, 8'h06, 4'b1111);
      do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      wait_cyc(127);
      push_frame(5, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'b1111);
      do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("pend_bnd_load", {31'h0, pending}, 32'h1);
      wait_cyc(129);
      chk("pend_bnd_keep", {31'h0, pending}, 32'h1);
      wait_cyc(159);
      chk("pend_bnd_hold", {31'h0, pending}, 32'h1);
      wait_cyc(160);
      chk("pend_bnd_fall", {31'h0, pending}, 32'h0);

      // Leading-zero suppression with dp on suppressed digit 3
      wait_cyc(163);
      push_frame(6, 8'h80, 8'h00, 8'h4F, 8'h3F, 4'b1111);
      do_load(16'h0030, 4'b1000, 4'b0000, 4'b0000, 1'b1);

      // Blink on digit 0: phase is 1 in frames 7 and 10, 0 in frames 8 and 9
      wait_cyc(195);
      push_frame(7,  8'h3F, 8'h3F, 8'h3F, 8'h00, 4'b1110);
      push_frame(8,  8'h3F, 8'h3F, 8'h3F, 8'h7F, 4'b1111);
      push_frame(9,  8'h3F, 8'h3F, 8'h3F, 8'h7F, 4'b1111);
      push_frame(10, 8'h3F, 8'h3F, 8'h3F, 8'h00, 4'b1110);
      do_load(16'h0008, 4'b0000, 4'b0000, 4'b0001, 1'b0);

      // Blank overrides blink in both phases
      wait_cyc(323);
      push_frame(11, 8'h3F, 8'h3F, 8'h3F, 8'h00, 4'b1110);
      push_frame(12, 8'h3F, 8'h3F, 8'h3F, 8'h00, 4'b1110);
      do_load(16'h0008, 4'b0000, 4'b0001, 4'b0001, 1'b0);

      // Asynchronous reset mid-slot with a load pending
      wait_cyc(428);
      chk("sb_empty_pre_rst", sb.size(), 32'h0);
      do_load(16'h4321, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      wait_cyc(430);
      chk("pend_pre_rst", {31'h0, pending}, 32'h1);
      chk("seg_w_pre_rst", {28'h0, seg_w}, 32'hD);
      chk("seg_d_pre_rst", {24'h0, seg_d}, 32'hC0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_seg_d", {24'h0, seg_d}, 32'hFF);
      chk("async_seg_w", {28'h0, seg_w}, 32'hF);
      chk("async_fs", {31'h0, frame_start}, 32'h0);
      chk("async_pending", {31'h0, pending}, 32'h0);
      repeat (3) @(negedge clk);
      push_frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      push_frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      rst_n = 1'b1;
      wait_cyc(10);
      chk("pend_post_rst", {31'h0, pending}, 32'h0);

      wait_cyc(64);
      for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
      chk("sb_drain", sb.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
